// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the pipeline and the HI/LO
// multiply/divide unit.
//   start, op, s_data, t_data : request side (driven by master)
//   busy, done, hi, lo        : status and architectural HI/LO (driven by slave)
interface muldiv_if #(
  parameter int unsigned WORD_SIZE = 32
);
  logic                 start;
  logic [2:0]           op;
  logic [WORD_SIZE-1:0] s_data;
  logic [WORD_SIZE-1:0] t_data;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] hi;
  logic [WORD_SIZE-1:0] lo;

  modport master (
    output start, op, s_data, t_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, s_data, t_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative MIPS-style HI/LO unit. MULT/MULTU by shift-add and
// DIV/DIVU by restoring division, one bit per cycle, followed by a one-cycle
// sign fix-up; MTHI/MTLO write HI/LO directly.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : muldiv_if.slave (start/op/s_data/t_data in, busy/done/hi/lo out)
module muldiv #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int unsigned W  = WORD_SIZE;
  localparam int unsigned CW = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_opnd;     // multiplicand or divisor magnitude
  logic [2*W-1:0]  r_acc;      // product, or {remainder, quotient}
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic            r_is_div;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;

  logic            w_signed;
  logic [W-1:0]    w_abs_s;
  logic [W-1:0]    w_abs_t;
  logic [W:0]      w_mul_sum;
  logic [W:0]      w_div_shift;
  logic [W+1:0]    w_div_diff;
  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_quo_fix;
  logic [W-1:0]    w_rem_fix;

  assign w_signed = ~bus.op[0];
  assign w_abs_s  = (w_signed && bus.s_data[W-1]) ? (-bus.s_data) : bus.s_data;
  assign w_abs_t  = (w_signed && bus.t_data[W-1]) ? (-bus.t_data) : bus.t_data;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Restoring step: shift next dividend bit into the remainder, trial subtract.
  assign w_div_shift = r_acc[2*W-1:W-1];
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};

  assign w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
  assign w_quo_fix  = r_neg_q ? (-r_acc[W-1:0]) : r_acc[W-1:0];
  assign w_rem_fix  = r_neg_r ? (-r_acc[2*W-1:W]) : r_acc[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_is_div <= bus.op[1];
                r_dz     <= (bus.t_data == '0);
                r_neg_q  <= w_signed & (bus.s_data[W-1] ^ bus.t_data[W-1]);
                r_neg_r  <= w_signed & bus.s_data[W-1];
                if (bus.op[1]) begin
                  r_opnd  <= w_abs_t;
                  r_acc   <= {{W{1'b0}}, w_abs_s};
                  r_state <= S_DIV;
                end else begin
                  r_opnd  <= w_abs_s;
                  r_acc   <= {{W{1'b0}}, w_abs_t};
                  r_state <= S_MUL;
                end
              end
              3'b100:  r_hi <= bus.s_data;
              3'b101:  r_lo <= bus.s_data;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[W-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) r_state <= S_FIXUP;
        end
        S_DIV: begin
          if (!w_div_diff[W+1])
            r_acc <= {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};
          else
            r_acc <= {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          if (r_is_div) begin
            // With a zero divisor every trial subtract succeeds, so the
            // remainder already ends up as s_data; only LO needs forcing.
            r_hi <= w_rem_fix;
            r_lo <= r_dz ? '1 : w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*W-1:W];
            r_lo <= w_prod_fix[W-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_if #(.WORD_SIZE(32)) u_if ();

  muldiv #(.WORD_SIZE(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one iterative op; optionally pulse a junk MULT start at cycle inj.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] s, input logic [31:0] t,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int inj);
    int lat;
    lat = 0;
    u_if.start  = 1'b1;
    u_if.op     = op;
    u_if.s_data = s;
    u_if.t_data = t;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    check({tag, ".busy"}, {63'd0, u_if.busy}, 64'd1);
    check({tag, ".done0"}, {63'd0, u_if.done}, 64'd0);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == inj) begin
        u_if.start  = 1'b1;
        u_if.op     = 3'b000;
        u_if.s_data = 32'h0000_0011;
        u_if.t_data = 32'h0000_0022;
      end else begin
        u_if.start = 1'b0;
      end
      if (i == 10) begin
        check({tag, ".hold_hi"}, {32'd0, u_if.hi}, {32'd0, exp_hi});
        check({tag, ".hold_lo"}, {32'd0, u_if.lo}, {32'd0, exp_lo});
      end
      if (u_if.done) begin
        lat = i;
        break;
      end
    end
    u_if.start = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'd33);
    check({tag, ".hi"}, {32'd0, u_if.hi}, {32'd0, ehi});
    check({tag, ".lo"}, {32'd0, u_if.lo}, {32'd0, elo});
    check({tag, ".busy_end"}, {63'd0, u_if.busy}, 64'd0);
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  task automatic move_op(input string tag, input logic [2:0] op, input logic [31:0] s);
    u_if.start  = 1'b1;
    u_if.op     = op;
    u_if.s_data = s;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    if (op == 3'b100) exp_hi = s;
    if (op == 3'b101) exp_lo = s;
    check({tag, ".hi"}, {32'd0, u_if.hi}, {32'd0, exp_hi});
    check({tag, ".lo"}, {32'd0, u_if.lo}, {32'd0, exp_lo});
    check({tag, ".busy"}, {63'd0, u_if.busy}, 64'd0);
    check({tag, ".done"}, {63'd0, u_if.done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst_n       = 1'b0;
    u_if.start  = 1'b0;
    u_if.op     = 3'b000;
    u_if.s_data = '0;
    u_if.t_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", {63'd0, u_if.busy}, 64'd0);
    check("rst.done", {63'd0, u_if.done}, 64'd0);
    check("rst.hi", {32'd0, u_if.hi}, 64'd0);
    check("rst.lo", {32'd0, u_if.lo}, 64'd0);
    rst_n = 1'b1;

    // Back-to-back: each op starts in the cycle where the previous done=1.
    run_op("mult",   3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("multu",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("div",    3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("divu0",  3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 0);
    run_op("div0",   3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
    run_op("divu",   3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 0);
    run_op("divpos", 3'b010, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 0);
    run_op("multbz", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);

    move_op("mtlo", 3'b101, 32'h1234_5678);
    move_op("mthi", 3'b100, 32'h9ABC_DEF0);
    move_op("nop6", 3'b110, 32'h5555_5555);
    move_op("nop7", 3'b111, 32'hAAAA_AAAA);

    // Abort a DIV with reset at cycle 10.
    u_if.start  = 1'b1;
    u_if.op     = 3'b010;
    u_if.s_data = 32'h0000_0064;
    u_if.t_data = 32'h0000_0007;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.busy", {63'd0, u_if.busy}, 64'd0);
    check("abort.hi", {32'd0, u_if.hi}, 64'd0);
    check("abort.lo", {32'd0, u_if.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (u_if.done) pulses++;
    end
    check("abort.nodone", 64'(pulses), 64'd0);
    check("abort.hi_after", {32'd0, u_if.hi}, 64'd0);
    check("abort.lo_after", {32'd0, u_if.lo}, 64'd0);
    check("abort.busy_after", {63'd0, u_if.busy}, 64'd0);

    run_op("postrst", 3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
